// File: rtl/mar_burst_if.sv
// mar_burst bus bundle: load/step/burst controls toward the MAR,
// registered address plus burst status flags back to the controller.
// Ports: d, lm, inc, burst_start, burst_len, rdy (to MAR);
//        addr, vld, busy, done, ovf (from MAR).
interface mar_burst_if #(
  parameter int AW = 4,
  parameter int LW = 2
);
  logic [AW-1:0] d;
  logic          lm;
  logic          inc;
  logic          burst_start;
  logic [LW-1:0] burst_len;
  logic          rdy;
  logic [AW-1:0] addr;
  logic          vld;
  logic          busy;
  logic          done;
  logic          ovf;

  modport master (
    output d,
    output lm,
    output inc,
    output burst_start,
    output burst_len,
    output rdy,
    input  addr,
    input  vld,
    input  busy,
    input  done,
    input  ovf
  );

  modport slave (
    input  d,
    input  lm,
    input  inc,
    input  burst_start,
    input  burst_len,
    input  rdy,
    output addr,
    output vld,
    output busy,
    output done,
    output ovf
  );
endinterface

// File: rtl/mar_burst.sv
// Memory address register with load, single-step increment and
// valid/ready sequential bursts; wrap or saturate chosen by WRAP.
// Ports: clk, clr (sync active-high reset), bus (mar_burst_if.slave).
module mar_burst #(
  parameter int AW   = 4,
  parameter int LW   = 2,
  parameter bit WRAP = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  mar_burst_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [AW-1:0] ONES = '1;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_nxt;
  logic [LW-1:0] cnt;
  logic [LW-1:0] cnt_nxt;
  logic          done;
  logic          done_nxt;
  logic          ovf;
  logic          ovf_nxt;

  logic          at_top;
  logic [AW-1:0] addr_inc;
  logic          ovf_inc;
  logic          ovf_hold;
  logic          last;

  assign at_top = (addr == ONES);
  assign last   = (cnt == '0);

  // Saturating mode pins the address at all-ones and latches ovf;
  // wrapping mode rolls to zero and flags only that one update.
  assign addr_inc = (at_top && !WRAP) ? ONES : addr + AW'(1);
  assign ovf_inc  = WRAP ? at_top : (ovf | at_top);
  assign ovf_hold = WRAP ? 1'b0 : ovf;

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!bus.lm) begin
          state_nxt = IDLE;
        end else if (bus.burst_start) begin
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (!bus.lm) begin
          state_nxt = IDLE;
        end else if (bus.rdy && last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_nxt = addr;
    cnt_nxt  = cnt;
    done_nxt = 1'b0;
    ovf_nxt  = ovf_hold;
    unique case (state)
      IDLE: begin
        if (!bus.lm) begin
          addr_nxt = bus.d;
          ovf_nxt  = 1'b0;
        end else if (bus.burst_start) begin
          cnt_nxt = bus.burst_len;
        end else if (bus.inc) begin
          addr_nxt = addr_inc;
          ovf_nxt  = ovf_inc;
        end
      end
      BURST: begin
        if (!bus.lm) begin
          addr_nxt = bus.d;
          ovf_nxt  = 1'b0;
        end else if (bus.rdy) begin
          addr_nxt = addr_inc;
          ovf_nxt  = ovf_inc;
          if (last) begin
            done_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt - LW'(1);
          end
        end
      end
      default: begin
        addr_nxt = addr;
      end
    endcase
  end

  assign bus.addr = addr;
  assign bus.vld  = (state == BURST);
  assign bus.busy = (state == BURST);
  assign bus.done = done;
  assign bus.ovf  = ovf;

endmodule

// File: tb/tb_mar_burst.sv
// Self-checking bench for mar_burst: wrapping and saturating copies
// driven in lockstep, checked against tables and a reference model.
module tb_mar_burst;

  logic       clk = 1'b0;
  logic       clr;
  logic       lm;
  logic       inc;
  logic       bst;
  logic       rdy;
  logic [3:0] d;
  logic [1:0] blen;

  always #5 clk = ~clk;

  mar_burst_if #(.AW(4), .LW(2)) bw ();
  mar_burst_if #(.AW(4), .LW(2)) bs ();

  assign bw.d           = d;
  assign bw.lm          = lm;
  assign bw.inc         = inc;
  assign bw.burst_start = bst;
  assign bw.burst_len   = blen;
  assign bw.rdy         = rdy;
  assign bs.d           = d;
  assign bs.lm          = lm;
  assign bs.inc         = inc;
  assign bs.burst_start = bst;
  assign bs.burst_len   = blen;
  assign bs.rdy         = rdy;

  mar_burst #(.AW(4), .LW(2), .WRAP(1'b1)) dut_w (
    .clk (clk),
    .clr (clr),
    .bus (bw)
  );

  mar_burst #(.AW(4), .LW(2), .WRAP(1'b0)) dut_s (
    .clk (clk),
    .clr (clr),
    .bus (bs)
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference model, index 0 = wrapping copy, 1 = saturating copy
  int m_addr [2];
  bit m_ovf  [2];
  int m_rem  [2];
  bit m_done [2];

  typedef struct {
    bit       clr;
    bit       lm;
    bit [3:0] d;
    bit       inc;
    bit       bst;
    bit [1:0] blen;
    bit       rdy;
    bit [3:0] addr_w;
    bit [3:0] addr_s;
    bit       ovf_w;
    bit       ovf_s;
    bit       vld;
    bit       done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit c, bit l, bit [3:0] dd, bit i,
                              bit b, bit [1:0] bl, bit r,
                              bit [3:0] aw, bit [3:0] as,
                              bit ow, bit os, bit v, bit dn);
    vec_t x;
    x.clr = c; x.lm = l; x.d = dd; x.inc = i;
    x.bst = b; x.blen = bl; x.rdy = r;
    x.addr_w = aw; x.addr_s = as;
    x.ovf_w = ow; x.ovf_s = os;
    x.vld = v; x.done = dn;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bump(int k);
    if (m_addr[k] == 15) begin
      m_ovf[k] = 1'b1;
      if (k == 0) m_addr[k] = 0;
    end else begin
      m_addr[k] = m_addr[k] + 1;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      if (k == 0) m_ovf[k] = 1'b0;
      if (clr) begin
        m_addr[k] = 0;
        m_ovf[k]  = 1'b0;
        m_rem[k]  = 0;
      end else if (!lm) begin
        m_addr[k] = int'(d);
        m_ovf[k]  = 1'b0;
        m_rem[k]  = 0;
      end else if (m_rem[k] == 0) begin
        if (bst) m_rem[k] = int'(blen) + 1;
        else if (inc) bump(k);
      end else if (rdy) begin
        bump(k);
        m_rem[k] = m_rem[k] - 1;
        if (m_rem[k] == 0) m_done[k] = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    chk("model_addr_w", 32'(bw.addr), 32'(m_addr[0]));
    chk("model_ovf_w",  32'(bw.ovf),  32'(m_ovf[0]));
    chk("model_vld_w",  32'(bw.vld),  32'(m_rem[0] != 0));
    chk("model_busy_w", 32'(bw.busy), 32'(m_rem[0] != 0));
    chk("model_done_w", 32'(bw.done), 32'(m_done[0]));
    chk("model_addr_s", 32'(bs.addr), 32'(m_addr[1]));
    chk("model_ovf_s",  32'(bs.ovf),  32'(m_ovf[1]));
    chk("model_vld_s",  32'(bs.vld),  32'(m_rem[1] != 0));
    chk("model_busy_s", 32'(bs.busy), 32'(m_rem[1] != 0));
    chk("model_done_s", 32'(bs.done), 32'(m_done[1]));
  endtask

  task automatic step(bit c, bit l, bit [3:0] dd, bit i,
                      bit b, bit [1:0] bl, bit r);
    clr = c; lm = l; d = dd; inc = i;
    bst = b; blen = bl; rdy = r;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic expect_o(string nm, bit [3:0] aw, bit [3:0] as,
                          bit ow, bit os, bit v, bit dn);
    chk({nm, "_addr_w"}, 32'(bw.addr), 32'(aw));
    chk({nm, "_addr_s"}, 32'(bs.addr), 32'(as));
    chk({nm, "_ovf_w"},  32'(bw.ovf),  32'(ow));
    chk({nm, "_ovf_s"},  32'(bs.ovf),  32'(os));
    chk({nm, "_vld"},    32'(bw.vld),  32'(v));
    chk({nm, "_busy"},   32'(bs.busy), 32'(v));
    chk({nm, "_done_w"}, 32'(bw.done), 32'(dn));
    chk({nm, "_done_s"}, 32'(bs.done), 32'(dn));
  endtask

  initial begin
    clr = 1'b1; lm = 1'b1; d = '0; inc = 1'b0;
    bst = 1'b0; blen = '0; rdy = 1'b0;

    //               clr lm d     inc bst blen rdy addr_w addr_s ow os v dn
    tbl.push_back(mk(1, 1, 4'h0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'hA, 0, 0, 0, 0, 4'hA, 4'hA, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'h3, 0, 0, 0, 0, 4'h3, 4'h3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'hC, 1, 0, 0, 0, 4'hC, 4'hC, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'h0, 1, 0, 0, 0, 4'hD, 4'hD, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'h3, 0, 0, 0, 0, 4'h3, 4'h3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'h0, 0, 1, 2, 0, 4'h3, 4'h3, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 0, 1, 4'h4, 4'h4, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 0, 0, 4'h4, 4'h4, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 0, 1, 4'h5, 4'h5, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 0, 1, 4'h6, 4'h6, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'h0, 0, 1, 0, 0, 4'h6, 4'h6, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 0, 1, 4'h7, 4'h7, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 0, 0, 4'h7, 4'h7, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'hE, 0, 0, 0, 0, 4'hE, 4'hE, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'h0, 0, 1, 3, 0, 4'hE, 4'hE, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 0, 1, 4'hF, 4'hF, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 0, 1, 4'h0, 4'hF, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 0, 1, 4'h1, 4'hF, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 0, 1, 4'h2, 4'hF, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 4'h0, 0, 0, 0, 0, 4'h2, 4'hF, 0, 1, 0, 0));

    foreach (tbl[n]) begin
      step(tbl[n].clr, tbl[n].lm, tbl[n].d, tbl[n].inc,
           tbl[n].bst, tbl[n].blen, tbl[n].rdy);
      expect_o($sformatf("tbl%0d", n), tbl[n].addr_w, tbl[n].addr_s,
               tbl[n].ovf_w, tbl[n].ovf_s, tbl[n].vld, tbl[n].done);
    end

    // saturation is sticky through idle cycles until a load
    step(0, 0, 4'hF, 0, 0, 0, 0);
    expect_o("sat_load", 4'hF, 4'hF, 0, 0, 0, 0);
    step(0, 1, 4'h0, 1, 0, 0, 0);
    expect_o("sat_inc", 4'h0, 4'hF, 1, 1, 0, 0);
    step(0, 1, 4'h0, 0, 0, 0, 0);
    expect_o("sat_idle1", 4'h0, 4'hF, 0, 1, 0, 0);
    step(0, 1, 4'h0, 0, 0, 0, 1);
    expect_o("sat_idle2", 4'h0, 4'hF, 0, 1, 0, 0);
    step(0, 0, 4'h5, 0, 0, 0, 0);
    expect_o("sat_clear", 4'h5, 4'h5, 0, 0, 0, 0);

    // abort mid-burst with rdy high: load wins, no done
    step(0, 1, 4'h0, 0, 1, 3, 0);
    expect_o("abt_start", 4'h5, 4'h5, 0, 0, 1, 0);
    step(0, 1, 4'h0, 1, 1, 0, 1);
    expect_o("abt_beat", 4'h6, 4'h6, 0, 0, 1, 0);
    step(0, 0, 4'h9, 0, 0, 0, 1);
    expect_o("abt_load", 4'h9, 4'h9, 0, 0, 0, 0);
    step(0, 1, 4'h0, 0, 0, 0, 1);
    expect_o("abt_after", 4'h9, 4'h9, 0, 0, 0, 0);

    // clr beats a simultaneous abort-load mid-burst
    step(0, 0, 4'hF, 0, 0, 0, 0);
    step(0, 1, 4'h0, 0, 1, 3, 0);
    expect_o("rst_start", 4'hF, 4'hF, 0, 0, 1, 0);
    step(0, 1, 4'h0, 0, 0, 0, 1);
    expect_o("rst_beat", 4'h0, 4'hF, 1, 1, 1, 0);
    step(1, 0, 4'h6, 1, 1, 0, 1);
    expect_o("rst_clr", 4'h0, 4'h0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 7) != 0,
           4'($urandom),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0,
           2'($urandom),
           $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mar_burst.md
# mar_burst

Parametrised memory address register for the SAP-style datapath; the successor to the fixed 4-bit MAR. It loads an address from `d` under active-low `lm`, supports single-step increment, and generates multi-beat sequential address bursts toward memory with a valid/ready handshake. Wrap-around or saturating overflow behaviour is selected at elaboration time.

## Interface
- `AW`, 4, address width in bits (≥2).
- `LW`, 2, burst-length field width; a burst carries `burst_len+1` beats (1..2^LW).
- `WRAP`, 1, 1 = increment past all-ones wraps to 0; 0 = saturate at all-ones.

- `clk`  in  1  rising-edge clock, the only clock.
- `clr`  in  1  synchronous, active-high reset; highest priority.
- `d`  in  AW  address source for load.
- `lm`  in  1  active-low load enable; 0 = load `d` into `addr`.
- `inc`  in  1  single-step increment request (IDLE only).
- `burst_start`  in  1  start burst from current `addr` (IDLE only).
- `burst_len`  in  LW  beats minus one, sampled with `burst_start`.
- `rdy`  in  1  memory accepts current address.
- `addr`  out  AW  registered address (the bus output).
- `vld`  out  1  `addr` is a valid burst beat.
- `busy`  out  1  state == BURST.
- `done`  out  1  one-cycle pulse after the final beat is accepted.
- `ovf`  out  1  overflow indication; semantics depend on `WRAP`.

## Operation
- Reset: when `clr`=1 at a rising edge: `addr`=0, `vld`=0, `busy`=0, `done`=0, `ovf`=0, beat counter=0, state=IDLE, regardless of any other input.
- States: IDLE, BURST. All outputs are registered.
- IDLE priority, highest first: `lm`=0 loads `d`, clears sticky `ovf`, and ignores `inc`/`burst_start` that cycle. Next, `burst_start`=1 captures `burst_len` into the counter and goes to BURST. Next, `inc`=1 performs a single increment. Otherwise `addr` holds.
- BURST: `vld`=1, `busy`=1. A beat is accepted on an edge with `rdy`=1. On each accepted beat `addr` post-increments (same overflow rules). If the counter is 0, go to IDLE and assert `done` for the next cycle; otherwise decrement the counter.
- `rdy`=0 in BURST: `addr` and the counter hold; `vld` stays 1.
- `lm`=0 in BURST aborts: load `d`, go to IDLE, `vld`=0, no `done`, clear `ovf`. `clr` overrides an abort.
- `inc` and `burst_start` are ignored in BURST.
- Increment arithmetic is unsigned modulo 2^AW before the overflow rule is applied.
  - `WRAP`=1: all-ones → 0, with `ovf` pulsing high for exactly one cycle.
  - `WRAP`=0: `addr` stays at all-ones and `ovf` is set sticky until `clr` or a load.
- After a burst of N beats from A, `addr` = A+N under the rule above. The MAR is left pointing at the next address.
- In a saturating burst, beats past all-ones still count and complete. `addr` repeats all-ones.

## Timing
- Load: `d` appears on `addr` the cycle after the edge where `lm`=0 is sampled (1-cycle latency).
- Increment: `addr`+1 is visible one cycle after the `inc` edge.
- Burst start: `vld`/`busy` rise one cycle after the `burst_start` edge. The first beat address is the `addr` value at start.
- With `rdy` held at 1, N beats take N cycles. `done`=1 in the cycle after the last accepted beat, coincident with `vld`=0 and `busy`=0.
- The earliest new `burst_start` is sampled in the cycle `done` is high (back-to-back bursts, 1-cycle gap).
- `ovf` changes in the same cycle as the `addr` update that caused it.

## Test plan
Parameters for all scenarios: AW=4, LW=2.
- Reset/load: `clr`=1 for one edge, then `d`=1010, `lm`=0 → `addr`=0000 after reset, then 1010; all flags 0.
- Load vs. inc priority: with `addr`=0011, `lm`=0, `d`=1100, `inc`=1 → `addr`=1100, no increment. Then `lm`=1, `inc`=1 → 1101.
- Burst with stalls: `addr`=0011, `burst_start`, `burst_len`=2, `rdy` pattern 1,0,1,1 → beats 0011, 0100, 0101. `addr` holds at 0100 during the stall. `done` pulses once, and final `addr`=0110.
- Wrap: WRAP=1, `addr`=1110, burst `burst_len`=3, `rdy`=1 → beats 1110, 1111, 0000, 0001. `ovf` pulses once on the 1111→0000 update; final `addr`=0010.
- Saturate: WRAP=0, `addr`=1111, `inc` → `addr`=1111, `ovf`=1 sticky. It stays set through idle cycles and clears on `lm`=0 with `d`=0101.
- Abort and reset mid-burst:
  - Abort: during BURST, `lm`=0 with `d`=0110 → `addr`=0110, IDLE, no `done`.
  - Reset: repeat the burst and assert `clr` with `lm`=0 → all outputs 0 next cycle.
